node_burst_scheduler: RTL

Shares the 256-bit input port of `small_buffer_ctrl` between `NUM_REQ` node producers. Grants one requester at a time in round-robin order, drives the buffer's `mode` and `num_of_line_per_node_minusone` for that burst, and passes exactly one node's worth of lines through. It holds off the next grant until the buffer reports node completion via `max_exponent_vld`. It sits directly upstream of `small_buffer_ctrl`.

---
 rtl/sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/node_burst_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and constants for the node burst scheduler
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        STREAM    = 2'b01,
        WAIT_DONE = 2'b10
    } sched_state_t;

    localparam int DEF_DATA_W     = 256;
    localparam int DEF_LINE_CNT_W = 11;

    localparam logic [1:0] MODE_0 = 2'b00;
    localparam logic [1:0] MODE_1 = 2'b01;
    localparam logic [1:0] MODE_2 = 2'b10;
    localparam logic [1:0] MODE_3 = 2'b11;

    localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after a pointer
module rr_arbiter
    import sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    // Scan requesters starting at ptr, wrapping, and take the first one asserted
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_burst_scheduler.sv
// rtl/node_burst_scheduler.sv - round-robin burst scheduler in front of small_buffer_ctrl (optional watchdog: SCHED_TIMEOUT_EN)
module node_burst_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_CNT_W  = DEF_LINE_CNT_W,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_start,
    input  logic [2*NUM_REQ-1:0]          req_mode,
    input  logic [LINE_CNT_W*NUM_REQ-1:0] req_lines_minusone,
    input  logic [DATA_W*NUM_REQ-1:0]     req_data,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [DATA_W-1:0]             buf_data,
    output logic                          buf_vld,
    input  logic                          buf_ready,
    output logic [1:0]                    buf_mode,
    output logic [LINE_CNT_W-1:0]         buf_lines_minusone,
    input  logic                          buf_done,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t            state;
    sched_state_t            state_next;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        g_idx;
    logic [PTR_W-1:0]        arb_idx;
    logic [PTR_W-1:0]        ptr_after;
    logic [LINE_CNT_W-1:0]   beat_cnt;
    logic [NUM_REQ-1:0]      arb_grant;
    logic                    arb_valid;
    logic                    beat_acc;
    logic                    last_beat;
    logic                    load_grant;
    logic                    finish;
    logic                    timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req_start),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Encode the arbiter's one-hot pick so the burst can be muxed by index
    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_grant[k]) begin
                arb_idx = PTR_W'(k);
            end
        end
    end

    assign ptr_after = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;

    // Zero-latency pass-through of the granted requester while streaming
    always_comb begin
        buf_data  = '0;
        buf_vld   = 1'b0;
        req_ready = '0;
        if (state == STREAM) begin
            buf_data         = req_data[int'(g_idx)*DATA_W +: DATA_W];
            buf_vld          = req_vld[g_idx];
            req_ready[g_idx] = buf_ready;
        end
    end

    // The compare uses the pre-increment count, so an all-ones limit never wraps
    assign beat_acc  = buf_vld & buf_ready;
    assign last_beat = beat_acc && (beat_cnt == buf_lines_minusone);
    assign busy      = (state != IDLE);

`ifdef SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TO_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYC - 1);
    logic [TIMEOUT_CNT_W-1:0] to_cnt;

    // Count consecutive cycles spent waiting for the buffer to finish the node
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == WAIT_DONE && state_next == WAIT_DONE) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
`endif

    // Next-state: a done seen with the last beat skips WAIT_DONE entirely
    always_comb begin
        state_next  = state;
        load_grant  = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    load_grant = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (last_beat) begin
                    if (buf_done) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (buf_done) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    finish      = 1'b1;
                    state_next  = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign err_timeout = timeout_hit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst context: captured once at grant and held until the burst retires
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_grant          <= '0;
            g_idx              <= '0;
            rr_ptr             <= '0;
            beat_cnt           <= '0;
            buf_mode           <= '0;
            buf_lines_minusone <= '0;
        end else begin
            if (load_grant) begin
                req_grant          <= arb_grant;
                g_idx              <= arb_idx;
                buf_mode           <= req_mode[int'(arb_idx)*2 +: 2];
                buf_lines_minusone <= req_lines_minusone[int'(arb_idx)*LINE_CNT_W +: LINE_CNT_W];
                beat_cnt           <= '0;
            end else if (beat_acc && !last_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (finish) begin
                req_grant <= '0;
                rr_ptr    <= ptr_after;
            end
        end
    end

endmodule
